// File: rtl/debug_pkg.sv
// Shared state encoding, halt-cause codes and control-output payload
// for the hart run-control sequencer.
package debug_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CAUSE_W = 3;
    localparam int unsigned CNT_W   = 8;

    localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd2;
    localparam logic [STATE_W-1:0] ST_HALTED = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESUME = 3'd4;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE      = 3'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_STEP      = 3'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_RESETHALT = 3'd5;

    // Core-facing control and DM status flags, registered together
    typedef struct packed {
        logic core_reset;
        logic core_stall;
        logic core_redirect;
        logic halted;
        logic running;
    } ctrl_t;

    // Highest-priority halt cause among events coinciding in RUN
    function automatic logic [CAUSE_W-1:0] run_halt_cause(
        input logic haltreq,
        input logic ebreak,
        input logic step_retire
    );
        logic [CAUSE_W-1:0] cause;
        cause = CAUSE_NONE;
        if (haltreq) begin
            cause = CAUSE_HALTREQ;
        end else if (ebreak) begin
            cause = CAUSE_EBREAK;
        end else if (step_retire) begin
            cause = CAUSE_STEP;
        end
        return cause;
    endfunction

endpackage

// File: rtl/debug_hart_ctrl.sv
// Run-control sequencer: turns DM haltreq/resumereq/hartreset into core
// reset/stall/redirect controls and reports halt/run/resume/reset status.
module debug_hart_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned XLEN         = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            I_HALTREQ,
    input  logic            I_RESUMEREQ,
    input  logic            I_HARTRESET,
    input  logic            I_ACKHAVERESET,
    input  logic            I_RESETHALTREQ,
    input  logic            I_STEP,
    input  logic            I_EBREAK,
    input  logic            I_RETIRE,
    input  logic            I_CORE_IDLE,
    input  logic [XLEN-1:0] I_PC,
    output logic            O_CORE_RESET,
    output logic            O_CORE_STALL,
    output logic            O_CORE_REDIRECT,
    output logic [XLEN-1:0] O_DPC,
    output logic [2:0]      O_DCAUSE,
    output logic            O_HALTED,
    output logic            O_RUNNING,
    output logic            O_RESUMEACK,
    output logic            O_HAVERESET
);

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_CYCLES);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_step_active;
    logic               w_step_nxt;
    logic [XLEN-1:0]    r_dpc;
    logic [XLEN-1:0]    w_dpc_nxt;
    logic [CAUSE_W-1:0] r_dcause;
    logic [CAUSE_W-1:0] w_dcause_nxt;
    logic [CAUSE_W-1:0] w_run_cause;
    logic               r_resumeack;
    logic               w_resumeack_nxt;
    logic               r_havereset;
    logic               w_havereset_nxt;
    ctrl_t              r_ctrl;
    ctrl_t              w_ctrl_nxt;

    assign w_run_cause = run_halt_cause(I_HALTREQ, I_EBREAK, r_step_active & I_RETIRE);

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state       <= ST_RESET;
            r_cnt         <= RST_CNT;
            r_step_active <= 1'b0;
            r_dpc         <= '0;
            r_dcause      <= CAUSE_NONE;
            r_resumeack   <= 1'b0;
            r_havereset   <= 1'b1;
            r_ctrl        <= '{core_reset: 1'b1, core_stall: 1'b0, core_redirect: 1'b0,
                               halted: 1'b0, running: 1'b0};
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_step_active <= w_step_nxt;
            r_dpc         <= w_dpc_nxt;
            r_dcause      <= w_dcause_nxt;
            r_resumeack   <= w_resumeack_nxt;
            r_havereset   <= w_havereset_nxt;
            r_ctrl        <= w_ctrl_nxt;
        end
    end

    // Next state, captured debug state and output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_step_nxt      = r_step_active;
        w_dpc_nxt       = r_dpc;
        w_dcause_nxt    = r_dcause;
        w_resumeack_nxt = r_resumeack;
        w_havereset_nxt = r_havereset & ~I_ACKHAVERESET;
        w_ctrl_nxt      = '0;

        case (r_state)
            ST_RESET: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt = '0;
                    if (I_RESETHALTREQ) begin
                        w_state_nxt  = ST_DRAIN;
                        w_dcause_nxt = CAUSE_RESETHALT;
                    end else begin
                        w_state_nxt  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_run_cause != CAUSE_NONE) begin
                    w_state_nxt  = ST_DRAIN;
                    w_dcause_nxt = w_run_cause;
                end
            end
            ST_DRAIN: begin
                if (I_CORE_IDLE) begin
                    w_dpc_nxt   = I_PC;
                    w_step_nxt  = 1'b0;
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // Resume is only accepted once halted has been reported to the DM
                if (r_ctrl.halted && !I_HALTREQ && I_RESUMEREQ) begin
                    w_resumeack_nxt = 1'b0;
                    w_step_nxt      = I_STEP;
                    w_state_nxt     = ST_RESUME;
                end
            end
            ST_RESUME: begin
                w_resumeack_nxt = 1'b1;
                w_state_nxt     = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RESET;
                w_cnt_nxt   = RST_CNT;
            end
        endcase

        // Hart reset overrides everything and restores the power-on debug state
        if (I_HARTRESET) begin
            w_state_nxt     = ST_RESET;
            w_cnt_nxt       = RST_CNT;
            w_step_nxt      = 1'b0;
            w_dpc_nxt       = '0;
            w_dcause_nxt    = CAUSE_NONE;
            w_resumeack_nxt = 1'b0;
            w_havereset_nxt = 1'b1;
        end

        w_ctrl_nxt.core_reset    = (w_state_nxt == ST_RESET);
        w_ctrl_nxt.core_stall    = (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_HALTED);
        w_ctrl_nxt.core_redirect = (w_state_nxt == ST_RESUME);
        w_ctrl_nxt.running       = (w_state_nxt == ST_RUN);
        w_ctrl_nxt.halted        = (w_state_nxt == ST_HALTED) && (r_state == ST_HALTED);
    end

    assign O_CORE_RESET    = r_ctrl.core_reset;
    assign O_CORE_STALL    = r_ctrl.core_stall;
    assign O_CORE_REDIRECT = r_ctrl.core_redirect;
    assign O_HALTED        = r_ctrl.halted;
    assign O_RUNNING       = r_ctrl.running;
    assign O_DPC           = r_dpc;
    assign O_DCAUSE        = r_dcause;
    assign O_RESUMEACK     = r_resumeack;
    assign O_HAVERESET     = r_havereset;

endmodule

// File: tb/tb_debug_hart_ctrl.sv
// Bench for debug_hart_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_debug_hart_ctrl;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        haltreq = 1'b0, resumereq = 1'b0, hartreset = 1'b0, ackhr = 1'b0;
    logic        rhr = 1'b0, step = 1'b0, ebreak = 1'b0, retire = 1'b0, idle = 1'b0;
    logic [31:0] pc = 32'h0;

    logic        o_core_reset, o_core_stall, o_core_redirect;
    logic [31:0] o_dpc;
    logic [2:0]  o_dcause;
    logic        o_halted, o_running, o_resumeack, o_havereset;

    debug_hart_ctrl #(.RESET_CYCLES(RC), .XLEN(32)) dut (
        .CLK(clk), .RST_N(rst_n),
        .I_HALTREQ(haltreq), .I_RESUMEREQ(resumereq), .I_HARTRESET(hartreset),
        .I_ACKHAVERESET(ackhr), .I_RESETHALTREQ(rhr), .I_STEP(step),
        .I_EBREAK(ebreak), .I_RETIRE(retire), .I_CORE_IDLE(idle), .I_PC(pc),
        .O_CORE_RESET(o_core_reset), .O_CORE_STALL(o_core_stall),
        .O_CORE_REDIRECT(o_core_redirect), .O_DPC(o_dpc), .O_DCAUSE(o_dcause),
        .O_HALTED(o_halted), .O_RUNNING(o_running), .O_RESUMEACK(o_resumeack),
        .O_HAVERESET(o_havereset)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: hart phase plus what the DM has been told
    localparam int M_RST = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3, M_RESUME = 4;
    int          m_mode, m_left, m_age, m_cause;
    logic [31:0] m_dpc;
    bit          m_step, m_ack, m_hr;

    always @(posedge clk) begin
        if (!rst_n || hartreset) begin
            m_mode = M_RST; m_left = RC; m_age = 0; m_cause = 0;
            m_dpc = 32'h0; m_step = 1'b0; m_ack = 1'b0; m_hr = 1'b1;
        end else begin
            if (ackhr) m_hr = 1'b0;
            case (m_mode)
                M_RST: begin
                    m_left = m_left - 1;
                    if (m_left <= 0) begin
                        if (rhr) begin m_mode = M_DRAIN; m_cause = 5; end
                        else m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (haltreq)                begin m_cause = 3; m_mode = M_DRAIN; end
                    else if (ebreak)            begin m_cause = 1; m_mode = M_DRAIN; end
                    else if (m_step && retire)  begin m_cause = 4; m_mode = M_DRAIN; end
                end
                M_DRAIN: begin
                    if (idle) begin m_dpc = pc; m_step = 1'b0; m_mode = M_HALT; m_age = 0; end
                end
                M_HALT: begin
                    if (m_age > 0 && !haltreq && resumereq) begin
                        m_ack = 1'b0; m_step = step; m_mode = M_RESUME;
                    end else begin
                        m_age = m_age + 1;
                    end
                end
                default: begin m_ack = 1'b1; m_mode = M_RUN; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_core_reset", 32'(o_core_reset),    32'(m_mode == M_RST));
            chk("m_core_stall", 32'(o_core_stall),    32'(m_mode == M_DRAIN || m_mode == M_HALT));
            chk("m_redirect",   32'(o_core_redirect), 32'(m_mode == M_RESUME));
            chk("m_running",    32'(o_running),       32'(m_mode == M_RUN));
            chk("m_halted",     32'(o_halted),        32'(m_mode == M_HALT && m_age > 0));
            chk("m_dpc",        o_dpc,                m_dpc);
            chk("m_dcause",     32'(o_dcause),        32'(m_cause));
            chk("m_resumeack",  32'(o_resumeack),     32'(m_ack));
            chk("m_havereset",  32'(o_havereset),     32'(m_hr));
        end
    end

    // Halt via haltreq with the core already idle; reports halted two edges later
    task automatic do_halt(input logic [31:0] at_pc);
        pc = at_pc; idle = 1'b1; haltreq = 1'b1;
        cyc(1);
        haltreq = 1'b0;
        chk("halt_stall", 32'(o_core_stall), 32'd1);
        cyc(1);
        chk("halt_not_yet", 32'(o_halted), 32'd0);
        cyc(1);
        chk("halt_min_latency", 32'(o_halted), 32'd1);
    endtask

    task automatic do_resume(input logic st);
        resumereq = 1'b1; step = st;
        cyc(1);
        resumereq = 1'b0; step = 1'b0;
        chk("resume_redirect", 32'(o_core_redirect), 32'd1);
        cyc(1);
        chk("resume_running", 32'(o_running), 32'd1);
    endtask

    initial begin
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        chk("rst_core_reset", 32'(o_core_reset), 32'd1);
        chk("rst_havereset",  32'(o_havereset),  32'd1);
        chk("rst_dpc",        o_dpc,             32'd0);

        // Reset release: core reset held for RC cycles
        rst_n = 1'b1;
        for (int i = 0; i < RC - 1; i++) begin
            cyc(1);
            chk("rel_reset_hold", 32'(o_core_reset), 32'd1);
        end
        cyc(1);
        chk("rel_reset_drop", 32'(o_core_reset), 32'd0);
        chk("rel_running",    32'(o_running),    32'd1);
        chk("rel_haverst",    32'(o_havereset),  32'd1);
        ackhr = 1'b1; cyc(1); ackhr = 1'b0;
        chk("ack_clears", 32'(o_havereset), 32'd0);

        // Halt request while core is still busy
        pc = 32'h80000104; idle = 1'b0; haltreq = 1'b1;
        cyc(1);
        chk("hr_stall",   32'(o_core_stall), 32'd1);
        chk("hr_running", 32'(o_running),    32'd0);
        haltreq = 1'b0;
        cyc(2);
        chk("hr_drain_wait", 32'(o_halted), 32'd0);
        idle = 1'b1;
        cyc(1);
        chk("hr_capture_dpc", o_dpc, 32'h80000104);
        cyc(1);
        chk("hr_halted", 32'(o_halted),  32'd1);
        chk("hr_dcause", 32'(o_dcause),  32'd3);

        // Resume blocked by a held haltreq, then accepted
        haltreq = 1'b1; resumereq = 1'b1;
        cyc(3);
        chk("blk_halted",   32'(o_halted),        32'd1);
        chk("blk_redirect", 32'(o_core_redirect), 32'd0);
        haltreq = 1'b0;
        cyc(1);
        chk("res_redirect", 32'(o_core_redirect), 32'd1);
        chk("res_ack_low",  32'(o_resumeack),     32'd0);
        chk("res_dpc",      o_dpc,                32'h80000104);
        resumereq = 1'b0;
        cyc(1);
        chk("res_running",  32'(o_running),   32'd1);
        chk("res_ack_high", 32'(o_resumeack), 32'd1);

        // Single step
        do_halt(32'h200);
        do_resume(1'b1);
        pc = 32'h204; retire = 1'b1;
        cyc(1);
        retire = 1'b0;
        cyc(2);
        chk("step_halted", 32'(o_halted), 32'd1);
        chk("step_dcause", 32'(o_dcause), 32'd4);
        chk("step_dpc",    o_dpc,         32'h204);

        // Coincident events: haltreq wins, then ebreak beats step
        do_resume(1'b1);
        pc = 32'h300; haltreq = 1'b1; ebreak = 1'b1; retire = 1'b1;
        cyc(1);
        haltreq = 1'b0; ebreak = 1'b0; retire = 1'b0;
        cyc(2);
        chk("all3_dcause", 32'(o_dcause), 32'd3);
        do_resume(1'b1);
        ebreak = 1'b1; retire = 1'b1;
        cyc(1);
        ebreak = 1'b0; retire = 1'b0;
        cyc(2);
        chk("ebrk_step_dcause", 32'(o_dcause), 32'd1);
        do_resume(1'b0);
        retire = 1'b1;
        cyc(3);
        retire = 1'b0;
        chk("nostep_running", 32'(o_running), 32'd1);
        ebreak = 1'b1;
        cyc(1);
        ebreak = 1'b0;
        cyc(2);
        chk("ebrk_dcause", 32'(o_dcause), 32'd1);
        chk("ebrk_halted", 32'(o_halted), 32'd1);

        // Hart reset during DRAIN, same-cycle ack, then reset-halt
        do_resume(1'b0);
        idle = 1'b0; haltreq = 1'b1;
        cyc(1);
        haltreq = 1'b0;
        hartreset = 1'b1; ackhr = 1'b1;
        cyc(1);
        hartreset = 1'b0; ackhr = 1'b0;
        chk("hrst_core_reset", 32'(o_core_reset), 32'd1);
        chk("hrst_halted",     32'(o_halted),     32'd0);
        chk("hrst_haverst",    32'(o_havereset),  32'd1);
        rhr = 1'b1; idle = 1'b1; pc = 32'h1000;
        cyc(RC - 1);
        chk("hrst_reload", 32'(o_core_reset), 32'd1);
        cyc(1);
        chk("rhr_drop",   32'(o_core_reset), 32'd0);
        chk("rhr_dcause", 32'(o_dcause),     32'd5);
        cyc(2);
        chk("rhr_halted", 32'(o_halted), 32'd1);
        chk("rhr_dpc",    o_dpc,         32'h1000);
        rhr = 1'b0;

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 599) != 0);
            hartreset = ($urandom_range(0, 149) == 0);
            haltreq   = ($urandom_range(0, 99) < 12);
            resumereq = ($urandom_range(0, 99) < 30);
            ackhr     = ($urandom_range(0, 99) < 5);
            rhr       = ($urandom_range(0, 99) < 40);
            step      = ($urandom_range(0, 99) < 35);
            ebreak    = ($urandom_range(0, 99) < 5);
            retire    = ($urandom_range(0, 99) < 40);
            idle      = ($urandom_range(0, 99) < 50);
            pc        = $urandom;
            cyc(1);
        end

        rst_n = 1'b1; hartreset = 1'b0; haltreq = 1'b0; resumereq = 1'b0;
        ackhr = 1'b0; ebreak = 1'b0; retire = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_hart_ctrl.md
Name: debug_hart_ctrl

Overview:
Run-control sequencer between the debug module's hart-control outputs and a single RV32 core. It turns haltreq/resumereq/hartreset into core stall, reset and PC-redirect controls. It captures DPC and DCAUSE on every halt and returns halted/running/resumeack/havereset status to the debug module. It replaces the ad-hoc halt/resume flops at the top level and adds single-step support.

Parameters:
RESET_CYCLES, 4, number of clocks O_CORE_RESET is held after any reset entry (1..255)
XLEN, 32, width of PC/DPC

Ports:
CLK  input  1  system clock
RST_N  input  1  reset, synchronous, active-low
I_HALTREQ  input  1  level halt request from DM
I_RESUMEREQ  input  1  level resume request from DM
I_HARTRESET  input  1  level hart reset request from DM
I_ACKHAVERESET  input  1  one-cycle pulse that clears havereset
I_RESETHALTREQ  input  1  halt immediately after reset release
I_STEP  input  1  dcsr.step value, sampled on resume
I_EBREAK  input  1  core executed ebreak with dcsr.ebreakm set (pulse)
I_RETIRE  input  1  core retired one instruction (pulse)
I_CORE_IDLE  input  1  core pipeline drained, no outstanding bus access
I_PC  input  XLEN  PC of next instruction to execute
O_CORE_RESET  output  1  core reset, active-high
O_CORE_STALL  output  1  freeze core fetch/issue
O_CORE_REDIRECT  output  1  one-cycle pulse: core loads O_DPC as next PC
O_DPC  output  XLEN  captured debug PC
O_DCAUSE  output  3  halt cause: 1 ebreak, 3 haltreq, 4 step, 5 resethaltreq
O_HALTED  output  1  hart halted
O_RUNNING  output  1  hart running
O_RESUMEACK  output  1  resume completed
O_HAVERESET  output  1  hart has been reset since last ack

Behaviour:
- This block has one clock and its reset is synchronous and active-low: CLK, RST_N.
- Reset (RST_N=0 at a CLK edge): state RESET, counter=RESET_CYCLES, O_CORE_RESET=1, O_CORE_STALL=0, O_CORE_REDIRECT=0, O_DPC=0, O_DCAUSE=0, O_HALTED=0, O_RUNNING=0, O_RESUMEACK=0, O_HAVERESET=1, step_active=0.
- All outputs are registered. States: RESET, RUN, DRAIN, HALTED, RESUME.
- RESET:
  - O_CORE_RESET=1; counter decrements each cycle.
  - When the counter reaches 0, O_CORE_RESET drops. If I_RESETHALTREQ=1, go to DRAIN with DCAUSE=5; otherwise go to RUN.
- I_HARTRESET=1 in any state: next state RESET, counter reloaded, O_HAVERESET=1, step_active=0. It has top priority over every other input.
- O_HAVERESET is cleared by I_ACKHAVERESET. If set and clear occur in the same cycle, set wins.
- RUN:
  - O_RUNNING=1, O_CORE_STALL=0.
  - Priority when several events coincide: I_HALTREQ (cause 3) > I_EBREAK (cause 1) > step_active and I_RETIRE (cause 4).
  - Any of these events: next state DRAIN, O_CORE_STALL=1 and O_RUNNING=0 from the next cycle, DCAUSE latched.
- DRAIN:
  - O_CORE_STALL=1. Wait for I_CORE_IDLE=1.
  - In the cycle I_CORE_IDLE=1 is sampled: DPC<=I_PC, step_active<=0, next state HALTED.
  - Minimum latency: I_HALTREQ sampled at edge n with I_CORE_IDLE already 1 at edge n+1 gives O_HALTED=1 after edge n+2.
  - I_HALTREQ deasserting during DRAIN does not abort the halt.
- HALTED:
  - O_HALTED=1, O_CORE_STALL=1.
  - If I_HALTREQ=1, stay in HALTED, ignoring I_RESUMEREQ; halt has priority per the debug spec.
  - Otherwise, I_RESUMEREQ=1: O_RESUMEACK<=0, step_active<=I_STEP, next state RESUME.
- RESUME, exactly one cycle:
  - O_CORE_REDIRECT=1 with O_DPC valid.
  - O_CORE_STALL=0, O_HALTED=0.
  - O_RESUMEACK<=1; next state RUN.
- O_RESUMEACK stays 1 until the next resume request is accepted or a reset occurs.
- O_HALTED and O_RUNNING are never both 1. Both are 0 in RESET, DRAIN and RESUME.
- Single step: after a resume with step_active=1, the first I_RETIRE in RUN halts with cause 4. I_EBREAK in the same cycle as that retire gives cause 1.
- O_DPC and O_DCAUSE hold their values until the next halt capture or reset.

Decomposition:
- Shared package debug_pkg:
  - state encoding localparams (RESET, RUN, DRAIN, HALTED, RESUME)
  - DCAUSE constants (CAUSE_EBREAK=3'd1, CAUSE_HALTREQ=3'd3, CAUSE_STEP=3'd4, CAUSE_RESETHALT=3'd5)
- No sub-module. A single FSM plus counter, about 200 lines.

Test Plan:
- Reset release, RESET_CYCLES=4, I_RESETHALTREQ=0 -> O_CORE_RESET high exactly 4 cycles after RST_N=1, then O_RUNNING=1; O_HAVERESET stays 1 until an I_ACKHAVERESET pulse, then 0.
- Halt request: RUN, I_PC=0x80000104, I_CORE_IDLE held 0 for 3 cycles then 1, I_HALTREQ=1 -> O_CORE_STALL=1 next cycle, O_HALTED=1 two cycles after idle is sampled, O_DPC=0x80000104, O_DCAUSE=3.
- Resume: HALTED, I_HALTREQ=0, I_RESUMEREQ=1 -> O_RESUMEACK 0 then 1, one O_CORE_REDIRECT pulse with O_DPC=0x80000104, O_RUNNING=1; with I_HALTREQ=1 held as well -> stays HALTED, no redirect.
- Single step: resume with I_STEP=1 and I_PC=0x200, then one I_RETIRE while I_PC=0x204 -> O_HALTED=1, O_DCAUSE=4, O_DPC=0x204.
- Simultaneous events in RUN: I_HALTREQ, I_EBREAK and I_RETIRE in one cycle with step active -> O_DCAUSE=3; I_EBREAK alone -> O_DCAUSE=1.
- Reset mid-operation:
  - I_HARTRESET=1 during DRAIN -> next cycle O_CORE_RESET=1, O_HALTED=0, O_HAVERESET=1, counter reloaded.
  - I_ACKHAVERESET in the same cycle as I_HARTRESET -> O_HAVERESET stays 1.
  - I_RESETHALTREQ=1 at reset release -> halt with O_DCAUSE=5.
